csr_trap_ctrl: RTL and testbench
================================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 4, giving the trap cause code width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port trap_valid, input, 1: the commit stage requests a trap entry.
REQ-005 SHALL have ports trap_is_int (input, 1), trap_code (input, CODE_W), trap_pc (input, 64) and trap_tval (input, 64): the interrupt flag, cause code, faulting PC and tval for that request.
REQ-006 SHALL have port mret_valid, input, 1: the commit stage requests an MRET.
REQ-007 SHALL have ports cur_mstatus, cur_mtvec and cur_mepc, each input, 64: live CSR-file values.
REQ-008 SHALL have ports sw_csr_valid (input, 1), sw_csr_addr (input, 12), sw_csr_data (input, 64) and sw_csr_ready (output, 1): the software CSR write request channel.
REQ-009 SHALL have ports csr_we (output, 1), csr_waddr (output, 12) and csr_wdata (output, 64): the single shared CSR-file write port.
REQ-010 SHALL have ports redirect_valid (output, 1), redirect_pc (output, 64) and redirect_ready (input, 1): the fetch redirect handshake.
REQ-011 SHALL have port busy, output, 1: a pipeline stall request, high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_RESTORE and REDIRECT.
REQ-013 SHALL sample requests in IDLE only, with priority trap_valid > mret_valid > sw_csr_valid; a request made outside IDLE is not sampled and the requester holds it until the block returns to IDLE.
REQ-014 SHALL, on trap acceptance, snapshot trap_pc, trap_tval, trap_is_int, trap_code, cur_mstatus and cur_mtvec into internal registers and move to W_MEPC.
REQ-015 SHALL write one CSR per cycle, csr_we=1: W_MEPC writes 12'h341 with {pc[63:2],2'b00}; W_MCAUSE writes 12'h342 with {is_int, zero-extended code}; W_MTVAL writes 12'h343 with tval; W_MSTATUS writes 12'h300.
REQ-016 SHALL form the W_MSTATUS value from the snapshot with mpie<=mie, mie<=0, mpp<=2'b11 and all other bits unchanged.
REQ-017 SHALL, on MRET acceptance, go to M_RESTORE and write 12'h300 with mie<=mpie, mpie<=1, mpp<=2'b00, using cur_mstatus sampled at acceptance; the redirect target is cur_mepc sampled at acceptance.
REQ-018 SHALL, in REDIRECT, hold redirect_valid=1 with redirect_pc stable until the cycle in which redirect_ready=1, then return to IDLE in the next cycle.
REQ-019 SHALL, for a trap, drive redirect_pc as {mtvec[63:2],2'b00}, subject to REQ-026.
REQ-020 SHALL drive sw_csr_ready=1 only when in IDLE with trap_valid=0 and mret_valid=0; on sw_csr_valid && sw_csr_ready, drive csr_we=1, csr_waddr=sw_csr_addr and csr_wdata=sw_csr_data combinationally in that same cycle, with no state change.
REQ-021 SHALL drive csr_we=0 in IDLE without a software write and in REDIRECT.
REQ-022 SHALL give a trap a total latency of 5 cycles from acceptance to the first redirect_valid, with 4 write cycles; an MRET SHALL give 2.
REQ-023 SHALL honour trap_valid and mret_valid being high together as the trap only; the MRET is dropped and the commit stage re-issues it if still architecturally required.
REQ-024 SHALL ignore request inputs while busy=1, so that trap_valid arriving during REDIRECT does not disturb the current sequence.

Reset
REQ-025 SHALL, when resetn=0 at a clock edge, enter IDLE and clear all snapshot registers to 0, with csr_we=0, redirect_valid=0, busy=0 and sw_csr_ready=0 while resetn=0; reset abandons any sequence mid-flight, and writes already issued are not undone.

Configuration
REQ-026 SHALL, when macro CSR_TRAP_VECTORED_EN is defined, the trap is an interrupt and mtvec[1:0]==2'b01, drive redirect_pc as {mtvec[63:2],2'b00} + 4*code; SHALL otherwise, and always when the macro is undefined, use direct mode per REQ-019 with mtvec[1:0] ignored.

Verification
REQ-027 SHALL cover: an exception with pc=0x8000_0010, code=2, tval=0xDEAD and mtvec=0x8000_1000 -> writes 341=0x8000_0010, 342=0x2, 343=0xDEAD, then 300 with mie=0/mpie=old mie/mpp=3; redirect_pc=0x8000_1000 on cycle 5.
REQ-028 SHALL cover: MRET with mstatus.mpie=1, mie=0 and mepc=0x8000_0014 -> 300 written with mie=1, mpie=1, mpp=0; redirect_pc=0x8000_0014 after 2 cycles.
REQ-029 SHALL cover: trap_valid, mret_valid and sw_csr_valid all high in IDLE -> the trap sequence runs, sw_csr_ready=0, and no MRET write occurs.
REQ-030 SHALL cover: redirect_ready held low for 3 cycles -> redirect_valid and redirect_pc stay stable, and IDLE is reached the cycle after ready rises.
REQ-031 SHALL cover: resetn low during W_MTVAL -> IDLE next cycle, all outputs 0, and a following software write to 0x340 accepted the cycle after resetn returns high.
REQ-032 SHALL cover, with CSR_TRAP_VECTORED_EN defined: an interrupt with code=7 and mtvec=0x8000_1001 -> redirect_pc=0x8000_101C; with the macro undefined, the same stimulus -> redirect_pc=0x8000_1000.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode trap entry / MRET sequencer sharing one CSR-file write port
// Optional vectored interrupt entry is enabled by defining CSR_TRAP_VECTORED_EN.
module csr_trap_ctrl #(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              trap_valid,
    input  logic              trap_is_int,
    input  logic [CODE_W-1:0] trap_code,
    input  logic [63:0]       trap_pc,
    input  logic [63:0]       trap_tval,
    input  logic              mret_valid,
    input  logic [63:0]       cur_mstatus,
    input  logic [63:0]       cur_mtvec,
    input  logic [63:0]       cur_mepc,
    input  logic              sw_csr_valid,
    input  logic [11:0]       sw_csr_addr,
    input  logic [63:0]       sw_csr_data,
    output logic              sw_csr_ready,
    output logic              csr_we,
    output logic [11:0]       csr_waddr,
    output logic [63:0]       csr_wdata,
    output logic              redirect_valid,
    output logic [63:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic              busy
);
    localparam int MIE  = 3;
    localparam int MPIE = 7;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_RESTORE, REDIRECT
    } state_e;

    state_e state_q, state_d;

    logic [63:0]       pc_q, tval_q, mstatus_q, mtvec_q, mepc_q;
    logic              is_int_q, is_mret_q;
    logic [CODE_W-1:0] code_q;
    logic [63:0]       trap_target, mstatus_trap, mstatus_mret;
    logic              accept_trap, accept_mret;
    logic              unused_bits;

    assign accept_trap = (state_q == IDLE) && trap_valid;
    assign accept_mret = (state_q == IDLE) && !trap_valid && mret_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_trap) begin
                pc_q      <= trap_pc;
                tval_q    <= trap_tval;
                is_int_q  <= trap_is_int;
                code_q    <= trap_code;
                mstatus_q <= cur_mstatus;
                mtvec_q   <= cur_mtvec;
                is_mret_q <= 1'b0;
            end else if (accept_mret) begin
                mstatus_q <= cur_mstatus;
                mepc_q    <= cur_mepc;
                is_mret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mstatus_trap          = mstatus_q;
        mstatus_trap[MPIE]    = mstatus_q[MIE];
        mstatus_trap[MIE]     = 1'b0;
        mstatus_trap[12:11]   = 2'b11;
        mstatus_mret          = mstatus_q;
        mstatus_mret[MIE]     = mstatus_q[MPIE];
        mstatus_mret[MPIE]    = 1'b1;
        mstatus_mret[12:11]   = 2'b00;
    end

`ifdef CSR_TRAP_VECTORED_EN
    // Vectored mode only applies to interrupts; exceptions always enter at the base.
    always_comb begin
        trap_target = {mtvec_q[63:2], 2'b00};
        if (is_int_q && (mtvec_q[1:0] == 2'b01))
            trap_target = {mtvec_q[63:2], 2'b00} + {{(62-CODE_W){1'b0}}, code_q, 2'b00};
    end
    assign unused_bits = ^pc_q[1:0];
`else
    assign trap_target = {mtvec_q[63:2], 2'b00};
    assign unused_bits = ^{pc_q[1:0], mtvec_q[1:0]};
`endif

    always_comb begin
        state_d        = state_q;
        sw_csr_ready   = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (trap_valid) begin
                    state_d = W_MEPC;
                end else if (mret_valid) begin
                    state_d = M_RESTORE;
                end else begin
                    sw_csr_ready = 1'b1;
                    if (sw_csr_valid) begin
                        csr_we    = 1'b1;
                        csr_waddr = sw_csr_addr;
                        csr_wdata = sw_csr_data;
                    end
                end
            end
            W_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h341;
                csr_wdata = {pc_q[63:2], 2'b00};
                state_d   = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h342;
                csr_wdata = {is_int_q, {(63-CODE_W){1'b0}}, code_q};
                state_d   = W_MTVAL;
            end
            W_MTVAL: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h343;
                csr_wdata = tval_q;
                state_d   = W_MSTATUS;
            end
            W_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = mstatus_trap;
                state_d   = REDIRECT;
            end
            M_RESTORE: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = mstatus_mret;
                state_d   = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_q ? mepc_q : trap_target;
                if (redirect_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced quiet for the whole time reset is asserted.
        if (!resetn) begin
            sw_csr_ready   = 1'b0;
            csr_we         = 1'b0;
            csr_waddr      = '0;
            csr_wdata      = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            busy           = 1'b0;
        end
    end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - randomized self-checking bench for csr_trap_ctrl against a behavioural model
module tb_csr_trap_ctrl;
    localparam int CODE_W = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              trap_valid, trap_is_int, mret_valid, sw_csr_valid, redirect_ready;
    logic [CODE_W-1:0] trap_code;
    logic [63:0]       trap_pc, trap_tval, cur_mstatus, cur_mtvec, cur_mepc, sw_csr_data;
    logic [11:0]       sw_csr_addr;
    logic              sw_csr_ready, csr_we, redirect_valid, busy;
    logic [11:0]       csr_waddr;
    logic [63:0]       csr_wdata, redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_addr[$];
    logic [63:0] exp_data[$];

    always #5 clk = ~clk;

    csr_trap_ctrl #(.CODE_W(CODE_W)) dut (
        .clk(clk), .resetn(resetn),
        .trap_valid(trap_valid), .trap_is_int(trap_is_int), .trap_code(trap_code),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
        .cur_mstatus(cur_mstatus), .cur_mtvec(cur_mtvec), .cur_mepc(cur_mepc),
        .sw_csr_valid(sw_csr_valid), .sw_csr_addr(sw_csr_addr), .sw_csr_data(sw_csr_data),
        .sw_csr_ready(sw_csr_ready), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mstatus bit masks: MIE=0x8, MPIE=0x80, MPP=0x1800
    function automatic logic [63:0] ms_after_trap(input logic [63:0] ms);
        return (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | 64'h1800;
    endfunction

    function automatic logic [63:0] ms_after_mret(input logic [63:0] ms);
        return (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
    endfunction

    function automatic logic [63:0] trap_entry(input logic is_int, input logic [3:0] code,
                                               input logic [63:0] mtvec);
        logic [63:0] base;
        base = mtvec & ~64'h3;
`ifdef CSR_TRAP_VECTORED_EN
        if (is_int && mtvec[1:0] == 2'b01)
            return base + 64'(4 * int'(code));
`endif
        return base;
    endfunction

    task automatic clear_req();
        trap_valid     = 1'b0;
        mret_valid     = 1'b0;
        sw_csr_valid   = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic noise();
        trap_valid   = 1'($urandom);
        mret_valid   = 1'($urandom);
        sw_csr_valid = 1'($urandom);
        trap_is_int  = 1'($urandom);
        trap_code    = 4'($urandom);
        trap_pc      = {$urandom, $urandom};
        trap_tval    = {$urandom, $urandom};
        cur_mstatus  = {$urandom, $urandom};
        cur_mtvec    = {$urandom, $urandom};
        cur_mepc     = {$urandom, $urandom};
        sw_csr_addr  = 12'($urandom);
        sw_csr_data  = {$urandom, $urandom};
    endtask

    task automatic collect(input logic [63:0] epc, input int lat, input int rdelay);
        int rc = 0;
        bit done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            noise();
            redirect_ready = 1'b0;
            #1;
            check("busy_in_seq", busy, 1);
            check("sw_ready_in_seq", sw_csr_ready, 0);
            if (csr_we) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_we", csr_we, 0);
                end else begin
                    check("waddr", csr_waddr, exp_addr.pop_front());
                    check("wdata", csr_wdata, exp_data.pop_front());
                end
            end
            if (redirect_valid) begin
                if (rc == 0) begin
                    check("redirect_latency", c, lat);
                    check("writes_missing", exp_addr.size(), 0);
                end
                check("redirect_pc", redirect_pc, epc);
                check("we_in_redirect", csr_we, 0);
                rc++;
                redirect_ready = (rc > rdelay);
                done = redirect_ready;
            end
        end
        if (!done) check("redirect_timeout", done, 1);
        @(negedge clk);
        clear_req();
        #1;
        check("back_idle_busy", busy, 0);
        check("back_idle_ready", sw_csr_ready, 1);
        check("back_idle_rv", redirect_valid, 0);
    endtask

    task automatic do_trap(input logic is_int, input logic [3:0] code, input logic [63:0] pc,
                           input logic [63:0] tval, input logic [63:0] ms, input logic [63:0] mtvec,
                           input int rdelay, input bit with_mret, input bit with_sw);
        @(negedge clk);
        clear_req();
        trap_valid   = 1'b1;
        trap_is_int  = is_int;
        trap_code    = code;
        trap_pc      = pc;
        trap_tval    = tval;
        cur_mstatus  = ms;
        cur_mtvec    = mtvec;
        cur_mepc     = {$urandom, $urandom};
        mret_valid   = with_mret;
        sw_csr_valid = with_sw;
        #1;
        check("trap_accept_sw_ready", sw_csr_ready, 0);
        check("trap_accept_we", csr_we, 0);
        exp_addr = {12'h341, 12'h342, 12'h343, 12'h300};
        exp_data = {pc & ~64'h3, (64'(is_int) << 63) | 64'(code), tval, ms_after_trap(ms)};
        collect(trap_entry(is_int, code, mtvec), 5, rdelay);
    endtask

    task automatic do_mret(input logic [63:0] ms, input logic [63:0] mepc, input int rdelay,
                           input bit with_sw);
        @(negedge clk);
        clear_req();
        mret_valid   = 1'b1;
        cur_mstatus  = ms;
        cur_mepc     = mepc;
        sw_csr_valid = with_sw;
        #1;
        check("mret_accept_sw_ready", sw_csr_ready, 0);
        check("mret_accept_we", csr_we, 0);
        exp_addr = {12'h300};
        exp_data = {ms_after_mret(ms)};
        collect(mepc, 2, rdelay);
    endtask

    task automatic do_sw(input logic [11:0] addr, input logic [63:0] data);
        @(negedge clk);
        clear_req();
        sw_csr_valid = 1'b1;
        sw_csr_addr  = addr;
        sw_csr_data  = data;
        #1;
        check("sw_ready", sw_csr_ready, 1);
        check("sw_we", csr_we, 1);
        check("sw_waddr", csr_waddr, addr);
        check("sw_wdata", csr_wdata, data);
        @(negedge clk);
        clear_req();
        #1;
        check("sw_no_state_change", busy, 0);
        check("sw_we_drop", csr_we, 0);
    endtask

    task automatic reset_mid_mtval();
        @(negedge clk);
        clear_req();
        trap_valid  = 1'b1;
        trap_is_int = 1'b0;
        trap_code   = 4'd5;
        trap_pc     = 64'h8000_0100;
        trap_tval   = 64'h1234;
        cur_mstatus = 64'h8;
        cur_mtvec   = 64'h8000_2000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear_req();
        end
        #1;
        check("rst_pre_waddr", csr_waddr, 12'h343);
        resetn = 1'b0;
        #1;
        check("rst_low_we", csr_we, 0);
        check("rst_low_busy", busy, 0);
        check("rst_low_rv", redirect_valid, 0);
        check("rst_low_sw_ready", sw_csr_ready, 0);
        @(negedge clk);
        #1;
        check("rst_idle_busy", busy, 0);
        check("rst_idle_we", csr_we, 0);
        resetn       = 1'b1;
        sw_csr_valid = 1'b1;
        sw_csr_addr  = 12'h340;
        sw_csr_data  = 64'hCAFE_F00D;
        #1;
        check("post_rst_sw_ready", sw_csr_ready, 1);
        check("post_rst_we", csr_we, 1);
        check("post_rst_waddr", csr_waddr, 12'h340);
        check("post_rst_wdata", csr_wdata, 64'hCAFE_F00D);
        @(negedge clk);
        clear_req();
        #1;
        check("post_rst_idle", busy, 0);
    endtask

    initial begin
        resetn = 1'b0;
        clear_req();
        noise();
        clear_req();
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_we", csr_we, 0);
        check("reset_rv", redirect_valid, 0);
        check("reset_sw_ready", sw_csr_ready, 0);
        resetn = 1'b1;
        #1;
        check("idle_sw_ready", sw_csr_ready, 1);
        check("idle_busy", busy, 0);

        do_trap(1'b0, 4'd2, 64'h8000_0010, 64'hDEAD, 64'h8, 64'h8000_1000, 0, 1'b0, 1'b0);
        do_mret(64'h80, 64'h8000_0014, 0, 1'b0);
        do_trap(1'b0, 4'd3, 64'h8000_0203, 64'hBEEF, 64'h1808, 64'h8000_3000, 0, 1'b1, 1'b1);
        do_trap(1'b1, 4'd11, 64'h8000_0400, 64'h0, 64'h0, 64'h8000_4000, 3, 1'b0, 1'b0);
        do_trap(1'b1, 4'd7, 64'h8000_0500, 64'h0, 64'h8, 64'h8000_1001, 0, 1'b0, 1'b0);
        check("vector_target_const", trap_entry(1'b1, 4'd7, 64'h8000_1001),
`ifdef CSR_TRAP_VECTORED_EN
              64'h8000_101C);
`else
              64'h8000_1000);
`endif
        do_sw(12'h305, 64'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: do_trap(1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                           {$urandom, $urandom},
                           {$urandom, $urandom} & ~64'h2 | 64'(($urandom_range(0, 1))),
                           $urandom_range(0, 3), 1'($urandom), 1'($urandom));
                1: do_mret({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3),
                           1'($urandom));
                default: do_sw(12'($urandom), {$urandom, $urandom});
            endcase
        end

        reset_mid_mtval();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
